// File: rtl/seven_seg_pkg.sv
// ============================================================================
// Module      : seven_seg_pkg
// Description : Shared segment patterns, error codes and capture FSM states
//               for the 4-digit active-low 7-segment display path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seven_seg_pkg;

    // Active-low {g,f,e,d,c,b,a} patterns, identical to the display driver's
    localparam logic [6:0] c_seg_0 = 7'h40;
    localparam logic [6:0] c_seg_1 = 7'h79;
    localparam logic [6:0] c_seg_2 = 7'h24;
    localparam logic [6:0] c_seg_3 = 7'h30;
    localparam logic [6:0] c_seg_4 = 7'h19;
    localparam logic [6:0] c_seg_5 = 7'h12;
    localparam logic [6:0] c_seg_6 = 7'h02;
    localparam logic [6:0] c_seg_7 = 7'h78;
    localparam logic [6:0] c_seg_8 = 7'h00;
    localparam logic [6:0] c_seg_9 = 7'h10;
    localparam logic [6:0] c_seg_a = 7'h08;
    localparam logic [6:0] c_seg_b = 7'h03;
    localparam logic [6:0] c_seg_c = 7'h46;
    localparam logic [6:0] c_seg_d = 7'h21;
    localparam logic [6:0] c_seg_e = 7'h06;
    localparam logic [6:0] c_seg_f = 7'h0E;

    localparam logic [1:0] c_err_none    = 2'b00;
    localparam logic [1:0] c_err_pattern = 2'b01;
    localparam logic [1:0] c_err_multi   = 2'b10;
    localparam logic [1:0] c_err_order   = 2'b11;

    typedef enum logic [0:0] {
        ST_SYNC    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seg_pattern_decode.sv
// ============================================================================
// Module      : seg_pattern_decode
// Description : Combinational reverse lookup of an active-low segment pattern
//               to its hex nibble; hit_o is low for non-hex patterns.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] nibble_o,
    output logic       hit_o
);

    always_comb begin
        nibble_o = 4'h0;
        hit_o    = 1'b1;
        case (pattern_i)
            c_seg_0: nibble_o = 4'h0;
            c_seg_1: nibble_o = 4'h1;
            c_seg_2: nibble_o = 4'h2;
            c_seg_3: nibble_o = 4'h3;
            c_seg_4: nibble_o = 4'h4;
            c_seg_5: nibble_o = 4'h5;
            c_seg_6: nibble_o = 4'h6;
            c_seg_7: nibble_o = 4'h7;
            c_seg_8: nibble_o = 4'h8;
            c_seg_9: nibble_o = 4'h9;
            c_seg_a: nibble_o = 4'hA;
            c_seg_b: nibble_o = 4'hB;
            c_seg_c: nibble_o = 4'hC;
            c_seg_d: nibble_o = 4'hD;
            c_seg_e: nibble_o = 4'hE;
            c_seg_f: nibble_o = 4'hF;
            default: hit_o    = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seven_seg_capture.sv
// ============================================================================
// Module      : seven_seg_capture
// Description : Reassembles frames from a multiplexed active-low 4-digit
//               7-segment bus into a 16-bit value and flags malformed scans.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int SEG_LAG = 1,
    parameter int TIMEOUT = 16
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    input  logic        dp,
    output logic [15:0] value,
    output logic [3:0]  dp_out,
    output logic        frame_valid,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        stale
);

    localparam logic [7:0] c_timeout = 8'(TIMEOUT);

    logic [3:0] w_an_al;

    generate
        if (SEG_LAG == 0) begin : g_no_lag
            assign w_an_al = an;
        end else begin : g_lag
            logic [3:0] an_pipe_q [SEG_LAG];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SEG_LAG; i++) an_pipe_q[i] <= 4'hF;
                end else begin
                    an_pipe_q[0] <= an;
                    for (int i = 1; i < SEG_LAG; i++) an_pipe_q[i] <= an_pipe_q[i-1];
                end
            end
            assign w_an_al = an_pipe_q[SEG_LAG-1];
        end
    endgenerate

    logic       w_single;
    logic       w_multi;
    logic [1:0] w_digit;
    logic [3:0] w_nib;
    logic       w_hit;
    logic       w_valid_strobe;

    always_comb begin
        w_single = 1'b1;
        w_digit  = 2'd0;
        case (w_an_al)
            4'b1110: w_digit = 2'd0;
            4'b1101: w_digit = 2'd1;
            4'b1011: w_digit = 2'd2;
            4'b0111: w_digit = 2'd3;
            default: w_single = 1'b0;
        endcase
        w_multi = (w_an_al != 4'hF) && !w_single;
    end

    seg_pattern_decode u_decode (
        .pattern_i (seg),
        .nibble_o  (w_nib),
        .hit_o     (w_hit)
    );

    assign w_valid_strobe = w_single && w_hit;

    state_t          state_q,    state_d;
    logic [1:0]      expect_q,   expect_d;
    logic [3:0][3:0] shadow_q,   shadow_d;
    logic [3:0]      shdots_q,   shdots_d;
    logic [7:0]      idle_q,     idle_d;
    logic [15:0]     value_q,    value_d;
    logic [3:0]      dp_out_q,   dp_out_d;
    logic            fv_q,       fv_d;
    logic            err_q,      err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            stale_q,    stale_d;

    always_comb begin
        state_d    = state_q;
        expect_d   = expect_q;
        shadow_d   = shadow_q;
        shdots_d   = shdots_q;
        value_d    = value_q;
        dp_out_d   = dp_out_q;
        fv_d       = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        stale_d    = stale_q;

        // Multi-anode outranks a simultaneous bad pattern
        if (w_multi) begin
            err_d      = 1'b1;
            err_code_d = c_err_multi;
            state_d    = ST_SYNC;
        end else if (w_single && !w_hit) begin
            err_d      = 1'b1;
            err_code_d = c_err_pattern;
            state_d    = ST_SYNC;
        end else if (w_valid_strobe) begin
            case (state_q)
                ST_SYNC: begin
                    if (w_digit == 2'd0) begin
                        shadow_d[0] = w_nib;
                        shdots_d[0] = ~dp;
                        expect_d    = 2'd1;
                        state_d     = ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (w_digit == expect_q) begin
                        shadow_d[w_digit] = w_nib;
                        shdots_d[w_digit] = ~dp;
                        if (expect_q == 2'd3) begin
                            value_d  = shadow_d;
                            dp_out_d = shdots_d;
                            fv_d     = 1'b1;
                            stale_d  = 1'b0;
                            state_d  = ST_SYNC;
                        end else begin
                            expect_d = expect_q + 2'd1;
                        end
                    end else if (w_digit == expect_q - 2'd1) begin
                        // Re-strobe of the digit just stored: latest sample wins
                        shadow_d[w_digit] = w_nib;
                        shdots_d[w_digit] = ~dp;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = c_err_order;
                        state_d    = ST_SYNC;
                    end
                end
                default: state_d = ST_SYNC;
            endcase
        end

        if (w_valid_strobe)         idle_d = 8'd0;
        else if (idle_q < c_timeout) idle_d = idle_q + 8'd1;
        else                         idle_d = c_timeout;

        if (idle_d == c_timeout) begin
            stale_d = 1'b1;
            state_d = ST_SYNC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SYNC;
            expect_q   <= 2'd0;
            shadow_q   <= '0;
            shdots_q   <= 4'h0;
            idle_q     <= 8'd0;
            value_q    <= 16'h0000;
            dp_out_q   <= 4'h0;
            fv_q       <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= c_err_none;
            stale_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            expect_q   <= expect_d;
            shadow_q   <= shadow_d;
            shdots_q   <= shdots_d;
            idle_q     <= idle_d;
            value_q    <= value_d;
            dp_out_q   <= dp_out_d;
            fv_q       <= fv_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            stale_q    <= stale_d;
        end
    end

    assign value       = value_q;
    assign dp_out      = dp_out_q;
    assign frame_valid = fv_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign stale       = stale_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_capture.sv
// ============================================================================
// Module      : tb_seven_seg_capture
// Description : Self-checking bench for seven_seg_capture (SEG_LAG=1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_capture;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg = 7'h7F;
    logic [3:0]  an = 4'hF;
    logic        dp = 1'b1;
    logic [15:0] value;
    logic [3:0]  dp_out;
    logic        frame_valid;
    logic        err;
    logic [1:0]  err_code;
    logic        stale;

    seven_seg_capture #(.SEG_LAG(1), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .an          (an),
        .dp          (dp),
        .value       (value),
        .dp_out      (dp_out),
        .frame_valid (frame_valid),
        .err         (err),
        .err_code    (err_code),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    // One aligned {anode, pattern, dot} pair plus optional hand expectations
    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        bit          chk;
        logic [15:0] value;
        logic [3:0]  dpo;
        logic        fv;
        logic        err;
        logic [1:0]  code;
        logic        stale;
    } vec_t;

    vec_t       vq[$];
    logic [6:0] pat [16];
    int         n_checks = 0;
    int         n_err = 0;
    int         row_no = 0;

    // Reference model: frame assembled as a growing list of digits
    logic [3:0]  gq_nib[$];
    logic        gq_dot[$];
    logic [15:0] m_value;
    logic [3:0]  m_dpo;
    logic        m_fv, m_err, m_stale;
    logic [1:0]  m_code;
    int          m_idle;

    function automatic void model_reset();
        gq_nib.delete(); gq_dot.delete();
        m_value = 16'h0; m_dpo = 4'h0; m_fv = 1'b0; m_err = 1'b0;
        m_code = 2'b00; m_stale = 1'b1; m_idle = 0;
    endfunction

    function automatic void model_err(logic [1:0] c);
        m_err = 1'b1; m_code = c;
        gq_nib.delete(); gq_dot.delete();
    endfunction

    function automatic void model_step(logic [3:0] a, logic [6:0] s, logic d);
        int lows;
        int k;
        int nib;
        bit valid;
        lows = 0; k = 0; nib = -1; valid = 0;
        m_fv = 1'b0; m_err = 1'b0;
        for (int j = 0; j < 4; j++) if (!a[j]) begin lows++; k = j; end
        for (int j = 0; j < 16; j++) if (pat[j] == s) nib = j;
        if (lows >= 2) model_err(2'b10);
        else if (lows == 1 && nib < 0) model_err(2'b01);
        else if (lows == 1) begin
            valid = 1;
            if (gq_nib.size() == 0) begin
                if (k == 0) begin gq_nib.push_back(4'(nib)); gq_dot.push_back(!d); end
            end else if (k == gq_nib.size()) begin
                gq_nib.push_back(4'(nib)); gq_dot.push_back(!d);
                if (gq_nib.size() == 4) begin
                    m_value = {gq_nib[3], gq_nib[2], gq_nib[1], gq_nib[0]};
                    m_dpo   = {gq_dot[3], gq_dot[2], gq_dot[1], gq_dot[0]};
                    m_fv = 1'b1; m_stale = 1'b0;
                    gq_nib.delete(); gq_dot.delete();
                end
            end else if (k == gq_nib.size() - 1) begin
                gq_nib[k] = 4'(nib); gq_dot[k] = !d;
            end else model_err(2'b11);
        end
        if (valid) m_idle = 0;
        else if (m_idle < TIMEOUT) m_idle++;
        if (m_idle == TIMEOUT) begin
            m_stale = 1'b1;
            gq_nib.delete(); gq_dot.delete();
        end
    endfunction

    function automatic logic [24:0] outs();
        return {value, dp_out, frame_valid, err, err_code, stale};
    endfunction

    task automatic check(string name, logic [24:0] act, logic [24:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (value,dp_out,fv,err,code,stale)", name, act, exp);
        end
    endtask

    function automatic void row(logic [3:0] a, logic [6:0] s, logic d, logic [15:0] v,
                                logic [3:0] o, logic f, logic e, logic [1:0] c, logic st);
        vec_t x;
        x.an = a; x.seg = s; x.dp = d; x.chk = 1;
        x.value = v; x.dpo = o; x.fv = f; x.err = e; x.code = c; x.stale = st;
        vq.push_back(x);
    endfunction

    function automatic void raw(logic [3:0] a, logic [6:0] s, logic d);
        vec_t x;
        x.an = a; x.seg = s; x.dp = d; x.chk = 0;
        x.value = '0; x.dpo = '0; x.fv = 0; x.err = 0; x.code = '0; x.stale = 0;
        vq.push_back(x);
    endfunction

    // Drives the anode one cycle ahead of its pattern, like a lagging display driver
    task automatic flush();
        vec_t cur;
        for (int i = -1; i < vq.size(); i++) begin
            an = (i + 1 < vq.size()) ? vq[i+1].an : 4'hF;
            if (i >= 0) begin
                cur = vq[i];
            end else begin
                cur.an = 4'hF; cur.seg = 7'h7F; cur.dp = 1'b1; cur.chk = 0;
            end
            seg = cur.seg;
            dp  = cur.dp;
            @(posedge clk);
            #1;
            model_step(cur.an, cur.seg, cur.dp);
            check("model", outs(), {m_value, m_dpo, m_fv, m_err, m_code, m_stale});
            if (cur.chk) begin
                row_no++;
                check($sformatf("row%0d", row_no), outs(),
                      {cur.value, cur.dpo, cur.fv, cur.err, cur.code, cur.stale});
            end
        end
        vq.delete();
    endtask

    initial begin
        int         mode;
        int         nb;
        logic [15:0] v;

        pat = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset", outs(), {16'h0000, 4'h0, 1'b0, 1'b0, 2'b00, 1'b1});

        // 1234 scanned twice, frame_valid lands two cycles after digit-3 strobe
        for (int r = 0; r < 2; r++) begin
            row(4'b1110, pat[4], 1, r ? 16'h1234 : 16'h0, 4'h0, 0, 0, 2'b00, r ? 1'b0 : 1'b1);
            row(4'b1101, pat[3], 1, r ? 16'h1234 : 16'h0, 4'h0, 0, 0, 2'b00, r ? 1'b0 : 1'b1);
            row(4'b1011, pat[2], 1, r ? 16'h1234 : 16'h0, 4'h0, 0, 0, 2'b00, r ? 1'b0 : 1'b1);
            row(4'b0111, pat[1], 1, 16'h1234, 4'h0, 1, 0, 2'b00, 0);
        end
        row(4'hF,    7'h7F,   1, 16'h1234, 4'h0, 0, 0, 2'b00, 0);
        row(4'b1110, pat[13], 1, 16'h1234, 4'h0, 0, 0, 2'b00, 0);
        row(4'b1101, pat[12], 1, 16'h1234, 4'h0, 0, 0, 2'b00, 0);
        row(4'b1011, pat[11], 0, 16'h1234, 4'h0, 0, 0, 2'b00, 0);
        row(4'b0111, pat[10], 1, 16'hABCD, 4'h4, 1, 0, 2'b00, 0);
        // bad pattern in digit-2 slot
        row(4'b1110, pat[5],  1, 16'hABCD, 4'h4, 0, 0, 2'b00, 0);
        row(4'b1101, pat[6],  1, 16'hABCD, 4'h4, 0, 0, 2'b00, 0);
        row(4'b1011, 7'h7F,   1, 16'hABCD, 4'h4, 0, 1, 2'b01, 0);
        row(4'b0111, pat[7],  1, 16'hABCD, 4'h4, 0, 0, 2'b01, 0);
        row(4'b1110, pat[15], 1, 16'hABCD, 4'h4, 0, 0, 2'b01, 0);
        row(4'b1101, pat[15], 1, 16'hABCD, 4'h4, 0, 0, 2'b01, 0);
        row(4'b1011, pat[0],  1, 16'hABCD, 4'h4, 0, 0, 2'b01, 0);
        row(4'b0111, pat[0],  1, 16'h00FF, 4'h0, 1, 0, 2'b01, 0);
        // multi-anode, then out-of-order digit
        row(4'b1110, pat[1],  1, 16'h00FF, 4'h0, 0, 0, 2'b01, 0);
        row(4'b1100, pat[2],  1, 16'h00FF, 4'h0, 0, 1, 2'b10, 0);
        row(4'b1101, pat[3],  1, 16'h00FF, 4'h0, 0, 0, 2'b10, 0);
        row(4'b1110, pat[0],  1, 16'h00FF, 4'h0, 0, 0, 2'b10, 0);
        row(4'b1101, pat[0],  1, 16'h00FF, 4'h0, 0, 0, 2'b10, 0);
        row(4'b0111, pat[0],  1, 16'h00FF, 4'h0, 0, 1, 2'b11, 0);
        // repeated strobes and a blank inside a frame
        row(4'b1110, pat[9],  1, 16'h00FF, 4'h0, 0, 0, 2'b11, 0);
        row(4'b1110, pat[8],  1, 16'h00FF, 4'h0, 0, 0, 2'b11, 0);
        row(4'hF,    7'h7F,   1, 16'h00FF, 4'h0, 0, 0, 2'b11, 0);
        row(4'b1101, pat[7],  1, 16'h00FF, 4'h0, 0, 0, 2'b11, 0);
        row(4'b1101, pat[6],  1, 16'h00FF, 4'h0, 0, 0, 2'b11, 0);
        row(4'b1011, pat[5],  1, 16'h00FF, 4'h0, 0, 0, 2'b11, 0);
        row(4'b0111, pat[4],  1, 16'h4568, 4'h0, 1, 0, 2'b11, 0);
        // stale rises on the 16th idle cycle, cleared by the next frame
        for (int b = 1; b <= TIMEOUT; b++)
            row(4'hF, 7'h7F, 1, 16'h4568, 4'h0, 0, 0, 2'b11, (b == TIMEOUT) ? 1'b1 : 1'b0);
        row(4'b1110, pat[4],  1, 16'h4568, 4'h0, 0, 0, 2'b11, 1);
        row(4'b1101, pat[3],  1, 16'h4568, 4'h0, 0, 0, 2'b11, 1);
        row(4'b1011, pat[2],  1, 16'h4568, 4'h0, 0, 0, 2'b11, 1);
        row(4'b0111, pat[1],  1, 16'h1234, 4'h0, 1, 0, 2'b11, 0);
        flush();

        // Asynchronous reset in the middle of a frame
        row(4'b1110, pat[8],  1, 16'h1234, 4'h0, 0, 0, 2'b11, 0);
        row(4'b1101, pat[7],  1, 16'h1234, 4'h0, 0, 0, 2'b11, 0);
        flush();
        #2 rst_n = 1'b0;
        #1 check("async_reset", outs(), {16'h0000, 4'h0, 1'b0, 1'b0, 2'b00, 1'b1});
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        row(4'b1110, pat[8],  1, 16'h0000, 4'h0, 0, 0, 2'b00, 1);
        row(4'b1101, pat[7],  1, 16'h0000, 4'h0, 0, 0, 2'b00, 1);
        row(4'b1011, pat[6],  1, 16'h0000, 4'h0, 0, 0, 2'b00, 1);
        row(4'b0111, pat[5],  1, 16'h5678, 4'h0, 1, 0, 2'b00, 0);
        flush();

        // Randomized scans, corruptions and idle gaps against the model
        for (int it = 0; it < 80; it++) begin
            mode = $urandom_range(0, 9);
            if (mode <= 5) begin
                v = 16'($urandom);
                for (int k = 0; k < 4; k++) begin
                    if ($urandom_range(0, 3) == 0) raw(4'hF, pat[$urandom_range(0, 15)], 1'b1);
                    raw(~(4'b0001 << k), pat[v[4*k +: 4]], 1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 5) == 0)
                        raw(~(4'b0001 << k), pat[$urandom_range(0, 15)], 1'($urandom_range(0, 1)));
                end
            end else if (mode == 6) begin
                raw(4'($urandom), 7'($urandom), 1'($urandom));
            end else if (mode == 7) begin
                raw(~(4'b0001 << $urandom_range(0, 3)), 7'($urandom), 1'b1);
            end else begin
                nb = $urandom_range(0, 20);
                for (int b = 0; b < nb; b++) raw(4'hF, 7'h7F, 1'b1);
            end
            flush();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
